data_mem_ctrl: RTL and testbench

Data-memory controller between the CPU's MEM-stage port (Data_MEM_* signals) and a fixed-latency, multi-cycle synchronous SRAM. It posts writes into a one-entry write buffer so stores never stall unless the buffer is busy. It serves loads from the buffer on an address hit, and otherwise runs a blocking SRAM read while asserting a stall back to the pipeline.

---
 rtl/data_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: posts CPU stores into a one-entry write buffer and
// serves loads from that buffer on a hit or from a fixed-latency SRAM otherwise.
module data_mem_ctrl #(
    parameter int DATA_MEM_ADDR_BITS = 16,
    parameter int WAIT_CYCLES        = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_MEM_ADDR_BITS-1:0] Data_MEM_Address,
    input  logic                          Data_MEM_Read_Enable,
    input  logic                          Data_MEM_Write_Enable,
    input  logic [31:0]                   Data_MEM_Write_Data,
    output logic [31:0]                   Data_MEM_Read_Data,
    output logic                          mem_stall,
    output logic                          sram_cs,
    output logic                          sram_we,
    output logic [DATA_MEM_ADDR_BITS-1:0] sram_addr,
    output logic [31:0]                   sram_wdata,
    input  logic [31:0]                   sram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RDONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t                        state_q, state_d;
    logic [3:0]                    cnt_q, cnt_d;
    logic                          wb_valid_q, wb_valid_d;
    logic [DATA_MEM_ADDR_BITS-1:0] wb_addr_q, wb_addr_d;
    logic [31:0]                   wb_data_q, wb_data_d;
    logic [DATA_MEM_ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [31:0]                   rd_data_q, rd_data_d;

    logic is_store_s, is_load_s, hit_s, miss_s, last_s, buf_free_s;

    // Request decode; a store wins when both enables are set.
    always_comb begin
        is_store_s = Data_MEM_Write_Enable;
        is_load_s  = Data_MEM_Read_Enable & ~Data_MEM_Write_Enable;
        hit_s      = is_load_s & wb_valid_q & (Data_MEM_Address == wb_addr_q);
        miss_s     = is_load_s & ~hit_s;
        last_s     = (cnt_q == LAST_CNT);
        buf_free_s = ~wb_valid_q & (state_q == IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= 32'd0;
            rd_addr_q  <= '0;
            rd_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Next-state: posting stores, draining the buffer, blocking reads.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        case (state_q)
            IDLE: begin
                if (is_store_s && !wb_valid_q) begin
                    wb_valid_d = 1'b1;
                    wb_addr_d  = Data_MEM_Address;
                    wb_data_d  = Data_MEM_Write_Data;
                    cnt_d      = 4'd0;
                    state_d    = WR;
                end else if (miss_s) begin
                    rd_addr_d = Data_MEM_Address;
                    cnt_d     = 4'd0;
                    state_d   = RD;
                end else begin
                    state_d = IDLE;
                end
            end
            WR: begin
                if (last_s) begin
                    wb_valid_d = 1'b0;
                    cnt_d      = 4'd0;
                    // A load that missed while draining goes straight to SRAM.
                    if (miss_s) begin
                        rd_addr_d = Data_MEM_Address;
                        state_d   = RD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RD: begin
                if (last_s) begin
                    rd_data_d = sram_rdata;
                    cnt_d     = 4'd0;
                    state_d   = RDONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: SRAM bus from state, stall and load data from state plus request.
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = 32'd0;
        case (state_q)
            WR: begin
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = wb_addr_q;
                sram_wdata = wb_data_q;
            end
            RD: begin
                sram_cs   = 1'b1;
                sram_addr = rd_addr_q;
            end
            default: begin
                sram_cs = 1'b0;
            end
        endcase

        if (is_store_s) begin
            mem_stall = ~buf_free_s;
        end else if (miss_s) begin
            mem_stall = (state_q != RDONE);
        end else begin
            mem_stall = 1'b0;
        end

        if (hit_s) begin
            Data_MEM_Read_Data = wb_data_q;
        end else begin
            Data_MEM_Read_Data = rd_data_q;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a cycle-level transaction model predicts
// accept cycles, load data and the SRAM bus; a monitor checks them each cycle.
module tb_data_mem_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr = 16'd0;
    logic        re = 1'b0, we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        mem_stall, sram_cs, sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    logic [15:0] addr1 = 16'd0;
    logic        re1 = 1'b0, we1 = 1'b0;
    logic [31:0] wdata1 = 32'd0;
    logic [31:0] rdata1, sram_wdata1, sram_rdata1;
    logic        mem_stall1, sram_cs1, sram_we1;
    logic [15:0] sram_addr1;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_ctrl #(.DATA_MEM_ADDR_BITS(16), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst),
        .Data_MEM_Address(addr), .Data_MEM_Read_Enable(re),
        .Data_MEM_Write_Enable(we), .Data_MEM_Write_Data(wdata),
        .Data_MEM_Read_Data(rdata), .mem_stall(mem_stall),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    data_mem_ctrl #(.DATA_MEM_ADDR_BITS(16), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .Data_MEM_Address(addr1), .Data_MEM_Read_Enable(re1),
        .Data_MEM_Write_Enable(we1), .Data_MEM_Write_Data(wdata1),
        .Data_MEM_Read_Data(rdata1), .mem_stall(mem_stall1),
        .sram_cs(sram_cs1), .sram_we(sram_we1), .sram_addr(sram_addr1),
        .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1)
    );

    function automatic logic [31:0] init_val(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    // SRAM: a write commits and read data is valid only in the last window cycle.
    logic [31:0] smem [int];
    int          scnt = 0;
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we && scnt == W - 1) smem[int'(sram_addr)] = sram_wdata;
            scnt <= (scnt == W - 1) ? 0 : scnt + 1;
        end else begin
            scnt <= 0;
        end
    end
    assign sram_rdata = (sram_cs && !sram_we && scnt == W - 1) ?
        (smem.exists(int'(sram_addr)) ? smem[int'(sram_addr)] : init_val(sram_addr)) : 32'd0;
    assign sram_rdata1 = (sram_cs1 && !sram_we1) ? 32'hCAFEF00D : 32'd0;

    // Reference model state.
    typedef struct {
        int          acc;
        bit          ld;
        logic [31:0] data;
    } exp_t;
    exp_t        sbq[$];
    logic [31:0] ref_mem [int];
    int          bus_kind [int];
    logic [15:0] bus_addr [int];
    logic [31:0] bus_wd   [int];
    int          free_at = 0, wb_lo = 1, wb_hi = 0;
    logic [15:0] wb_a = 16'd0;
    logic [31:0] wb_d = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Issue one request at the current cycle, predict its outcome, hold until accepted.
    task automatic do_req(input bit st, input bit both, input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        int t, start, n;
        t = cyc;
        e.ld = !st;
        e.data = 32'd0;
        if (st) begin
            e.acc = (t > free_at) ? t : free_at;
            for (int c = e.acc + 1; c <= e.acc + W; c++) begin
                bus_kind[c] = 1; bus_addr[c] = a; bus_wd[c] = d;
            end
            free_at = e.acc + W + 1;
            wb_lo = e.acc + 1; wb_hi = e.acc + W; wb_a = a; wb_d = d;
            ref_mem[int'(a)] = d;
        end else if (t >= wb_lo && t <= wb_hi && a == wb_a) begin
            e.acc = t;
            e.data = wb_d;
        end else begin
            start = (t + 1 > free_at) ? t + 1 : free_at;
            for (int c = start; c < start + W; c++) begin
                bus_kind[c] = 2; bus_addr[c] = a;
            end
            e.acc = start + W;
            free_at = e.acc + 1;
            e.data = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
        end
        sbq.push_back(e);
        addr = a; wdata = d; we = st; re = !st || both;
        n = 0;
        forever begin
            @(negedge clk);
            if (!mem_stall) break;
            n++;
            if (n > 60) begin
                vectors++; errors++;
                $display("FAIL accept_timeout: request to 0x%0h still stalled, required accept by cycle %0d", a, e.acc);
                if (sbq.size() > 0) void'(sbq.pop_front());
                break;
            end
        end
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
    endtask

    task automatic gap(input int g);
        repeat (g) begin @(posedge clk); #1; end
    endtask

    // Monitor: SRAM bus every cycle, accept timing and load data on each accept.
    exp_t        me;
    int          mk;
    logic [31:0] mwd;
    always @(negedge clk) begin
        mk  = bus_kind.exists(cyc) ? bus_kind[cyc] : 0;
        mwd = (mk == 2) ? 32'd0 : sram_wdata;
        chk("sram_bus", {sram_cs, sram_we, sram_addr, mwd},
            {mk != 0, mk == 1, (mk != 0) ? bus_addr[cyc] : 16'd0, (mk == 1) ? bus_wd[cyc] : 32'd0});
        if (re || we) begin
            if (!mem_stall) begin
                if (sbq.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL spurious_accept: accept in cycle %0d with nothing expected", cyc);
                end else begin
                    me = sbq.pop_front();
                    chk("accept_cycle", 64'(cyc), 64'(me.acc));
                    if (me.ld) chk("load_data", rdata, me.data);
                end
            end
        end else begin
            chk("idle_stall", mem_stall, 1'b0);
        end
    end

    initial begin
        ref_mem[int'(16'h0040)] = 32'hA5A5A5A5; smem[int'(16'h0040)] = 32'hA5A5A5A5;
        ref_mem[int'(16'h0100)] = 32'hCAFEF00D; smem[int'(16'h0100)] = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {sram_cs, sram_we, sram_addr, sram_wdata},  50'd0);
        chk("rst_read_data", rdata, 32'd0);
        chk("rst_stall", mem_stall, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Reset in the first write cycle: the access aborts and the store is lost.
        do_req(1'b1, 1'b0, 16'h0050, 32'h0BADF00D);
        #2 rst = 1'b0;
        for (int c = cyc; c < cyc + 8; c++) if (bus_kind.exists(c)) bus_kind.delete(c);
        ref_mem.delete(int'(16'h0050));
        free_at = 0; wb_lo = 1; wb_hi = 0;
        #1;
        chk("rst_mid_wr_cs", sram_cs, 1'b0);
        chk("rst_mid_wr_stall", mem_stall, 1'b0);
        chk("rst_mid_wr_data", rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        do_req(1'b0, 1'b0, 16'h0050, 32'd0);
        gap(2);

        // Directed cases: posted store, back-to-back stores, hit, miss during drain, idle miss.
        do_req(1'b1, 1'b0, 16'h0010, 32'hDEADBEEF);
        gap(3);
        do_req(1'b1, 1'b0, 16'h0010, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 16'h0014, 32'h11112222);
        gap(3);
        do_req(1'b1, 1'b0, 16'h0020, 32'h12345678);
        do_req(1'b0, 1'b0, 16'h0020, 32'd0);
        gap(3);
        do_req(1'b1, 1'b0, 16'h0030, 32'h30303030);
        do_req(1'b0, 1'b0, 16'h0040, 32'd0);
        gap(2);
        do_req(1'b0, 1'b0, 16'h0100, 32'd0);
        do_req(1'b0, 1'b0, 16'h0010, 32'd0);
        do_req(1'b1, 1'b1, 16'h0014, 32'h77778888);
        do_req(1'b0, 1'b0, 16'h0014, 32'd0);

        // Random traffic over a small address set so hits and misses both occur.
        for (int i = 0; i < 300; i++) begin
            do_req(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                   16'h0010 + 16'(4 * $urandom_range(0, 5)), $urandom);
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
        end
        gap(6);

        // Single-cycle SRAM instance: idle load miss and back-to-back stores.
        addr1 = 16'h0100; re1 = 1'b1;
        @(negedge clk); chk("w1_load_stall_c0", mem_stall1, 1'b1);
        @(negedge clk); chk("w1_load_stall_c1", mem_stall1, 1'b1);
        @(negedge clk); chk("w1_load_stall_c2", mem_stall1, 1'b0);
        chk("w1_load_data_c2", rdata1, 32'hCAFEF00D);
        @(posedge clk); #1 re1 = 1'b0; we1 = 1'b1; addr1 = 16'h0010; wdata1 = 32'h0000AAAA;
        @(negedge clk); chk("w1_store_stall_c0", mem_stall1, 1'b0);
        @(posedge clk); #1 addr1 = 16'h0014; wdata1 = 32'h0000BBBB;
        @(negedge clk); chk("w1_wr_cs_c1", {sram_cs1, sram_we1, sram_addr1}, {2'b11, 16'h0010});
        chk("w1_store2_stall_c1", mem_stall1, 1'b1);
        @(negedge clk); chk("w1_store2_stall_c2", mem_stall1, 1'b0);
        @(posedge clk); #1 we1 = 1'b0;
        @(negedge clk); chk("w1_wr2", {sram_cs1, sram_we1, sram_addr1, sram_wdata1},
                            {2'b11, 16'h0014, 32'h0000BBBB});
        gap(2);

        if (sbq.size() != 0) begin
            vectors++; errors++;
            $display("FAIL scoreboard_drain: %0d expected accepts never seen, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
